// File: rtl/axil_cmd_manager.sv
// axil_cmd_manager: valid/ready command stream to AXI-Lite manager bridge, one transaction in flight.
// Optional wait-state abort enabled by defining AXIL_MGR_TIMEOUT_EN.
module axil_cmd_manager #(
  parameter int AXI_LITE_ADDR_WIDTH = 32,
  parameter int AXI_LITE_DATA_WIDTH = 32,
  parameter int AXI_LITE_RESP_WIDTH = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_cmd_valid,
  output logic                           o_cmd_ready,
  input  logic                           i_cmd_write,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [AXI_LITE_DATA_WIDTH-1:0] i_cmd_wdata,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic                           o_rsp_write,
  output logic [AXI_LITE_DATA_WIDTH-1:0] o_rsp_rdata,
  output logic [AXI_LITE_RESP_WIDTH-1:0] o_rsp_resp,
  output logic                           o_rsp_timeout,
  output logic                           o_awvalid,
  input  logic                           i_awready,
  output logic [AXI_LITE_ADDR_WIDTH-1:0] o_awaddr,
  output logic                           o_wvalid,
  input  logic                           i_wready,
  output logic [AXI_LITE_DATA_WIDTH-1:0] o_wdata,
  input  logic                           i_bvalid,
  output logic                           o_bready,
  input  logic [AXI_LITE_RESP_WIDTH-1:0] i_bresp,
  output logic                           o_arvalid,
  input  logic                           i_arready,
  output logic [AXI_LITE_ADDR_WIDTH-1:0] o_araddr,
  input  logic                           i_rvalid,
  output logic                           o_rready,
  input  logic [AXI_LITE_DATA_WIDTH-1:0] i_rdata,
  input  logic [AXI_LITE_RESP_WIDTH-1:0] i_rresp
);
  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_t;
  state_t state;
  logic abort;
`ifdef AXIL_MGR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic hs;
  assign hs = (o_awvalid && i_awready) || (o_wvalid && i_wready) || (o_bready && i_bvalid) ||
              (o_arvalid && i_arready) || (o_rready && i_rvalid);
  // Counter is zero outside the wait states, so a match can only occur while waiting.
  always_ff @(posedge i_clk)
    wait_cnt <= (i_reset || hs || state == IDLE || state == RSP) ? '0 : wait_cnt + 1'b1;
  assign abort = !hs && wait_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign abort = 1'b0;
`endif
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      o_cmd_ready   <= 1'b1;
      o_rsp_valid   <= 1'b0;
      o_rsp_write   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_resp    <= '0;
      o_rsp_timeout <= 1'b0;
      o_awvalid     <= 1'b0;
      o_awaddr      <= '0;
      o_wvalid      <= 1'b0;
      o_wdata       <= '0;
      o_bready      <= 1'b0;
      o_arvalid     <= 1'b0;
      o_araddr      <= '0;
      o_rready      <= 1'b0;
    end else if (abort) begin
      state         <= RSP;
      o_awvalid     <= 1'b0;
      o_wvalid      <= 1'b0;
      o_bready      <= 1'b0;
      o_arvalid     <= 1'b0;
      o_rready      <= 1'b0;
      o_rsp_valid   <= 1'b1;
      o_rsp_rdata   <= '0;
      o_rsp_resp    <= AXI_LITE_RESP_WIDTH'(2);
      o_rsp_timeout <= 1'b1;
    end else begin
      case (state)
        IDLE: if (i_cmd_valid) begin
          o_cmd_ready   <= 1'b0;
          o_rsp_write   <= i_cmd_write;
          o_rsp_timeout <= 1'b0;
          if (i_cmd_write) begin
            o_awaddr  <= i_cmd_addr;
            o_wdata   <= i_cmd_wdata;
            o_awvalid <= 1'b1;
            o_wvalid  <= 1'b1;
            state     <= WR;
          end else begin
            o_araddr  <= i_cmd_addr;
            o_arvalid <= 1'b1;
            state     <= RD_AR;
          end
        end
        WR: begin
          if (i_awready) o_awvalid <= 1'b0;
          if (i_wready) o_wvalid <= 1'b0;
          if ((!o_awvalid || i_awready) && (!o_wvalid || i_wready)) begin
            o_bready <= 1'b1;
            state    <= WR_B;
          end
        end
        WR_B: if (i_bvalid) begin
          o_bready    <= 1'b0;
          o_rsp_resp  <= i_bresp;
          o_rsp_rdata <= '0;
          o_rsp_valid <= 1'b1;
          state       <= RSP;
        end
        RD_AR: if (i_arready) begin
          o_arvalid <= 1'b0;
          o_rready  <= 1'b1;
          state     <= RD_R;
        end
        RD_R: if (i_rvalid) begin
          o_rready    <= 1'b0;
          o_rsp_rdata <= i_rdata;
          o_rsp_resp  <= i_rresp;
          o_rsp_valid <= 1'b1;
          state       <= RSP;
        end
        RSP: if (i_rsp_ready) begin
          o_rsp_valid <= 1'b0;
          o_cmd_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_cmd_manager.sv
// tb_axil_cmd_manager: randomized bench with a latency-configurable AXI-Lite subordinate and a memory model.
module tb_axil_cmd_manager;
  localparam int AW = 32, DW = 32, RW = 2, TO = 16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic i_reset, i_cmd_valid, o_cmd_ready, i_cmd_write, o_rsp_valid, i_rsp_ready, o_rsp_write, o_rsp_timeout;
  logic [AW-1:0] i_cmd_addr, o_awaddr, o_araddr;
  logic [DW-1:0] i_cmd_wdata, o_rsp_rdata, o_wdata, i_rdata;
  logic [RW-1:0] o_rsp_resp, i_bresp, i_rresp;
  logic o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready, o_arvalid, i_arready, i_rvalid, o_rready;
  axil_cmd_manager #(
    .AXI_LITE_ADDR_WIDTH(AW), .AXI_LITE_DATA_WIDTH(DW), .AXI_LITE_RESP_WIDTH(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_write(i_cmd_write), .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp)
  );
  int checks = 0, fails = 0;
  logic [DW-1:0] smem [logic [AW-1:0]];
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  int aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  bit ar_never = 0, spurious = 0, aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
  logic [RW-1:0] sub_bresp = '0, sub_rresp = '0;
  logic [AW-1:0] aw_a;
  logic [DW-1:0] w_d, r_d;
  typedef struct {
    logic write; logic [DW-1:0] rdata; logic [RW-1:0] resp; logic to;
    int lat, awv, wv, bv, arv, rv;
    bit accepted, got_rsp, stable, held_ok, done_ok;
  } obs_t;
  // Resolve handshakes the DUT is about to sample at the coming edge.
  task automatic sub_commit();
    if (i_reset) begin
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      return;
    end
    if (o_awvalid && i_awready) begin aw_got = 1; aw_a = o_awaddr; aw_cnt = 0; end
    if (o_wvalid && i_wready) begin w_got = 1; w_d = o_wdata; w_cnt = 0; end
    if (aw_got && w_got) begin smem[aw_a] = w_d; aw_got = 0; w_got = 0; b_pend = 1; b_cnt = b_lat; end
    if (o_bready && i_bvalid && b_pend) b_pend = 0;
    if (o_arvalid && i_arready) begin
      r_pend = 1; r_cnt = r_lat; ar_cnt = 0;
      r_d = smem.exists(o_araddr) ? smem[o_araddr] : ~o_araddr;
    end
    if (o_rready && i_rvalid && r_pend) r_pend = 0;
  endtask
  task automatic sub_drive();
    i_awready = o_awvalid && aw_cnt >= aw_lat;
    if (o_awvalid) aw_cnt++;
    i_wready = o_wvalid && w_cnt >= w_lat;
    if (o_wvalid) w_cnt++;
    i_bvalid = spurious || (b_pend && b_cnt == 0);
    if (b_pend && b_cnt > 0) b_cnt--;
    i_bresp = sub_bresp;
    i_arready = !ar_never && o_arvalid && ar_cnt >= ar_lat;
    if (o_arvalid) ar_cnt++;
    i_rvalid = spurious || (r_pend && r_cnt == 0);
    if (r_pend && r_cnt > 0) r_cnt--;
    i_rdata = r_pend ? r_d : DW'($urandom);
    i_rresp = sub_rresp;
  endtask
  task automatic step();
    sub_commit();
    @(negedge clk);
    sub_drive();
  endtask
  // Issues one command and records what the DUT shows; comparisons live in the test tasks.
  task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold, output obs_t o);
    bit acc;
    o = '{default: 0};
    i_cmd_valid = 1; i_cmd_write = w; i_cmd_addr = a; i_cmd_wdata = d;
    for (int i = 0; i < 20 && !o.accepted; i++) begin
      acc = o_cmd_ready;
      step();
      o.accepted = acc;
    end
    i_cmd_valid = 0; i_cmd_write = 1'($urandom); i_cmd_addr = AW'($urandom); i_cmd_wdata = DW'($urandom);
    if (!o.accepted) return;
    o.lat = 1; o.stable = 1;
    while (!o_rsp_valid && o.lat < 100) begin
      o.awv += int'(o_awvalid); o.wv += int'(o_wvalid); o.bv += int'(o_bready);
      o.arv += int'(o_arvalid); o.rv += int'(o_rready);
      if ((o_awvalid && o_awaddr !== a) || (o_wvalid && o_wdata !== d) || (o_arvalid && o_araddr !== a)) o.stable = 0;
      step();
      o.lat++;
    end
    if (!o_rsp_valid) return;
    o.got_rsp = 1; o.write = o_rsp_write; o.rdata = o_rsp_rdata; o.resp = o_rsp_resp; o.to = o_rsp_timeout;
    o.held_ok = !o_cmd_ready;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!o_rsp_valid || o_cmd_ready || o_rsp_write !== o.write || o_rsp_rdata !== o.rdata ||
          o_rsp_resp !== o.resp || o_rsp_timeout !== o.to) o.held_ok = 0;
    end
    i_rsp_ready = 1;
    step();
    i_rsp_ready = 0;
    o.done_ok = !o_rsp_valid && o_cmd_ready;
  endtask
  task automatic test_reset();
    i_reset = 1;
    repeat (3) step();
    i_reset = 0;
    step();
    checks++; if (o_cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b want 1", o_cmd_ready); end
    checks++;
    if ({o_rsp_valid, o_rsp_write, o_rsp_timeout, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready} !== 8'h00) begin
      fails++; $display("FAIL reset_ctrl: got %b want 00000000",
        {o_rsp_valid, o_rsp_write, o_rsp_timeout, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready});
    end
    checks++;
    if ({o_awaddr, o_wdata, o_araddr, o_rsp_rdata, o_rsp_resp} !== '0) begin
      fails++; $display("FAIL reset_data: awaddr %h wdata %h araddr %h rdata %h resp %b want all 0",
        o_awaddr, o_wdata, o_araddr, o_rsp_rdata, o_rsp_resp);
    end
  endtask
  task automatic test_write_basic();
    obs_t o;
    sub_bresp = 2'b00;
    do_cmd(1'b1, 32'd6, 32'd30, 0, o);
    model_mem[32'd6] = 32'd30;
    checks++; if (!o.got_rsp || o.write !== 1'b1 || o.rdata !== '0 || o.resp !== 2'b00 || o.to !== 1'b0) begin
      fails++; $display("FAIL wr_basic_rsp: got rsp=%0b write=%b rdata=%h resp=%b to=%b want 1 1 0 00 0",
        o.got_rsp, o.write, o.rdata, o.resp, o.to);
    end
    checks++; if (o.lat != 3) begin fails++; $display("FAIL wr_basic_latency: got %0d want 3", o.lat); end
    checks++; if (o.awv != 1 || o.wv != 1 || o.bv != 1) begin
      fails++; $display("FAIL wr_basic_valid_cycles: aw=%0d w=%0d b=%0d want 1 1 1", o.awv, o.wv, o.bv);
    end
    checks++; if (!o.done_ok) begin fails++; $display("FAIL wr_basic_return_idle: got %0b want 1", o.done_ok); end
  endtask
  task automatic test_write_aw_delay();
    obs_t o;
    aw_lat = 2;
    do_cmd(1'b1, 32'd3, 32'hAABBCCDD, 0, o);
    aw_lat = 0;
    model_mem[32'd3] = 32'hAABBCCDD;
    checks++; if (o.wv != 1 || o.awv != 3) begin
      fails++; $display("FAIL wr_delay_valids: wvalid=%0d awvalid=%0d cycles want 1 3", o.wv, o.awv);
    end
    checks++; if (!o.stable) begin fails++; $display("FAIL wr_delay_stable: got %0b want 1", o.stable); end
    checks++; if (!o.got_rsp || o.resp !== 2'b00 || !o.done_ok) begin
      fails++; $display("FAIL wr_delay_rsp: got rsp=%0b resp=%b done=%0b want 1 00 1", o.got_rsp, o.resp, o.done_ok);
    end
  endtask
  task automatic test_read_hold();
    obs_t o;
    smem[32'd8] = 32'h1234ABCD;
    model_mem[32'd8] = 32'h1234ABCD;
    sub_rresp = 2'b00;
    do_cmd(1'b0, 32'd8, DW'($urandom), 5, o);
    checks++; if (!o.got_rsp || o.rdata !== 32'h1234ABCD || o.write !== 1'b0 || o.resp !== 2'b00) begin
      fails++; $display("FAIL rd_data: got rsp=%0b rdata=%h write=%b resp=%b want 1 1234abcd 0 00",
        o.got_rsp, o.rdata, o.write, o.resp);
    end
    checks++; if (!o.held_ok) begin fails++; $display("FAIL rd_hold: got %0b want 1", o.held_ok); end
    checks++; if (!o.done_ok) begin fails++; $display("FAIL rd_release: got %0b want 1", o.done_ok); end
  endtask
  task automatic test_back_to_back();
    obs_t o1, o2;
    logic [DW-1:0] wd;
    wd = DW'($urandom);
    do_cmd(1'b1, 32'd12, wd, 2, o1);
    model_mem[32'd12] = wd;
    do_cmd(1'b0, 32'd12, '0, 0, o2);
    checks++; if (!o1.held_ok || !o1.done_ok) begin
      fails++; $display("FAIL b2b_first_hold: held=%0b done=%0b want 1 1", o1.held_ok, o1.done_ok);
    end
    checks++; if (!o2.got_rsp || o2.rdata !== model_mem[32'd12]) begin
      fails++; $display("FAIL b2b_readback: got %h want %h", o2.rdata, model_mem[32'd12]);
    end
    checks++; if (o2.lat != 3) begin fails++; $display("FAIL b2b_read_latency: got %0d want 3", o2.lat); end
  endtask
  task automatic test_spurious();
    bit ok = 1;
    spurious = 1;
    repeat (4) begin
      step();
      if (o_rsp_valid || o_bready || o_rready || !o_cmd_ready) ok = 0;
    end
    spurious = 0;
    step();
    checks++; if (!ok) begin fails++; $display("FAIL spurious_ignored: got %0b want 1", ok); end
  endtask
  task automatic test_reset_mid();
    obs_t o;
    bit quiet = 1;
    b_lat = 20;
    i_cmd_valid = 1; i_cmd_write = 1; i_cmd_addr = 32'd100; i_cmd_wdata = 32'hCAFE0001;
    step();
    i_cmd_valid = 0;
    for (int i = 0; i < 10 && !o_bready; i++) step();
    checks++; if (o_bready !== 1'b1) begin fails++; $display("FAIL rst_mid_reach_wrb: got %b want 1", o_bready); end
    model_mem[32'd100] = 32'hCAFE0001;
    i_reset = 1;
    step();
    checks++; if ({o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid} !== 6'b0) begin
      fails++; $display("FAIL rst_mid_drop: got %b want 000000",
        {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid});
    end
    i_reset = 0;
    b_lat = 0;
    repeat (3) begin
      step();
      if (!o_cmd_ready || o_rsp_valid || o_bready || o_awvalid || o_wvalid) quiet = 0;
    end
    checks++; if (!quiet) begin fails++; $display("FAIL rst_mid_idle: got %0b want 1", quiet); end
    do_cmd(1'b0, 32'd100, '0, 0, o);
    checks++; if (!o.got_rsp || o.rdata !== model_mem[32'd100]) begin
      fails++; $display("FAIL rst_mid_recover: got %h want %h", o.rdata, model_mem[32'd100]);
    end
  endtask
`ifdef AXIL_MGR_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    ar_never = 1;
    do_cmd(1'b0, 32'h40, '0, 0, o);
    ar_never = 0;
    ar_cnt = 0;
    checks++; if (!o.got_rsp || o.resp !== 2'b10 || o.to !== 1'b1 || o.rdata !== '0) begin
      fails++; $display("FAIL timeout_rsp: got rsp=%0b resp=%b to=%b rdata=%h want 1 10 1 0",
        o.got_rsp, o.resp, o.to, o.rdata);
    end
    checks++; if (o.arv != TO || o.lat != TO + 1) begin
      fails++; $display("FAIL timeout_cycles: arvalid=%0d lat=%0d want %0d %0d", o.arv, o.lat, TO, TO + 1);
    end
  endtask
`else
  task automatic test_timeout();
    obs_t o;
    ar_lat = 40;
    do_cmd(1'b0, 32'd8, '0, 0, o);
    ar_lat = 0;
    checks++; if (!o.got_rsp || o.to !== 1'b0 || o.rdata !== model_mem[32'd8] || o.arv != 41) begin
      fails++; $display("FAIL long_wait: rsp=%0b to=%b rdata=%h arvalid=%0d want 1 0 %h 41",
        o.got_rsp, o.to, o.rdata, o.arv, model_mem[32'd8]);
    end
  endtask
`endif
  task automatic test_random();
    obs_t o;
    logic w;
    logic [AW-1:0] a;
    logic [DW-1:0] d, exp_rdata;
    logic [RW-1:0] exp_resp;
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom); a = AW'($urandom_range(0, 7) * 4); d = DW'($urandom);
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); b_lat = $urandom_range(0, 3);
      ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
      sub_bresp = RW'($urandom); sub_rresp = RW'($urandom);
      exp_resp = w ? sub_bresp : sub_rresp;
      exp_rdata = w ? '0 : (model_mem.exists(a) ? model_mem[a] : ~a);
      if (w) model_mem[a] = d;
      do_cmd(w, a, d, $urandom_range(0, 3), o);
      checks++;
      if (!o.got_rsp || o.write !== w || o.rdata !== exp_rdata || o.resp !== exp_resp || o.to !== 1'b0 ||
          !o.stable || !o.held_ok || !o.done_ok || o.lat < 3) begin
        fails++; $display("FAIL random_%0d: got write=%b rdata=%h resp=%b to=%b lat=%0d ok=%0b%0b%0b%0b want %b %h %b 0",
          n, o.write, o.rdata, o.resp, o.to, o.lat, o.got_rsp, o.stable, o.held_ok, o.done_ok, w, exp_rdata, exp_resp);
      end
    end
    aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0;
  endtask
  initial begin
    i_reset = 1; i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = '0; i_cmd_wdata = '0; i_rsp_ready = 0;
    i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = '0; i_arready = 0; i_rvalid = 0; i_rdata = '0; i_rresp = '0;
    test_reset();
    test_write_basic();
    test_write_aw_delay();
    test_read_hold();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule

// File: doc/axil_cmd_manager.md
Name: axil_cmd_manager

Overview:
- Simple-command to AXI-Lite manager bridge, one transaction in flight.
- Sits directly upstream of the AXI-Lite test subordinate and drives its aw/w/b/ar/r channels.
- Replaces hand-driven testbench stimulus with a valid/ready command stream from control-API logic.
- Returns one response beat per command: read data or write ack, plus resp code.

Parameters:
- AXI_LITE_ADDR_WIDTH, 32, address width of command and AXI address channels
- AXI_LITE_DATA_WIDTH, 32, data width of command, wdata and rdata
- AXI_LITE_RESP_WIDTH, 2, width of bresp/rresp and response resp field
- TIMEOUT_CYCLES, 256, wait-state cycle limit; used only with AXIL_MGR_TIMEOUT_EN; must be ≥2

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command ready
- i_cmd_write  in  1  1=write, 0=read
- i_cmd_addr  in  AXI_LITE_ADDR_WIDTH  target address
- i_cmd_wdata  in  AXI_LITE_DATA_WIDTH  write data, ignored for reads
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response ready
- o_rsp_write  out  1  echo of command type
- o_rsp_rdata  out  AXI_LITE_DATA_WIDTH  read data; 0 for writes
- o_rsp_resp  out  AXI_LITE_RESP_WIDTH  bresp/rresp captured
- o_rsp_timeout  out  1  transaction aborted by timeout
- o_awvalid, i_awready  out/in  1  AXI write address handshake
- o_awaddr  out  AXI_LITE_ADDR_WIDTH  write address
- o_wvalid, i_wready  out/in  1  AXI write data handshake
- o_wdata  out  AXI_LITE_DATA_WIDTH  write data
- i_bvalid, o_bready  in/out  1  AXI write response handshake
- i_bresp  in  AXI_LITE_RESP_WIDTH  write response
- o_arvalid, i_arready  out/in  1  AXI read address handshake
- o_araddr  out  AXI_LITE_ADDR_WIDTH  read address
- i_rvalid, o_rready  in/out  1  AXI read data handshake
- i_rdata  in  AXI_LITE_DATA_WIDTH  read data
- i_rresp  in  AXI_LITE_RESP_WIDTH  read response

Behaviour:
- Reset: all outputs 0 except o_cmd_ready=1 on the first cycle after reset deassert. State=IDLE.
- All outputs are registered; no combinational input-to-output path.
- FSM states: IDLE, WR (aw+w outstanding), WR_B, RD_AR, RD_R, RSP.

IDLE:
- o_cmd_ready=1.
- On i_cmd_valid, latch addr/wdata/write into address, data and type registers.
- Write: o_awvalid=o_wvalid=1 next cycle, goto WR.
- Read: o_arvalid=1 next cycle, goto RD_AR.

WR:
- aw and w are independent. Each valid drops the cycle after its own handshake.
- Same-cycle acceptance of both is legal.
- Address, data and valid are held stable until accepted.
- Once both have been accepted: o_bready=1, goto WR_B.

WR_B:
- On i_bvalid&&o_bready: capture i_bresp, o_bready=0, rdata=0, goto RSP.

RD_AR:
- On i_arready: o_arvalid=0, o_rready=1, goto RD_R.

RD_R:
- On i_rvalid: capture i_rdata and i_rresp, o_rready=0, goto RSP.

RSP:
- o_rsp_valid=1, fields held stable until i_rsp_ready.
- On i_rsp_ready: o_rsp_valid=0, o_cmd_ready=1, goto IDLE.
- Minimum command-to-response latency is 3 cycles with an always-ready subordinate.
- Throughput is one transaction per ≥4 cycles.

Boundary conditions:
- i_bvalid or i_rvalid arriving outside its wait state is ignored; the matching ready is 0 there.
- i_reset mid-transaction forces IDLE immediately and drops every valid/ready the same cycle. The response is discarded.
- Non-OKAY bresp/rresp is passed through unmodified; it is not an error for this block.

Optional Feature:
- Macro: AXIL_MGR_TIMEOUT_EN.
- Enabled:
  - A wait counter clears on entry to WR, WR_B, RD_AR and RD_R, and on every completed AXI handshake.
  - It increments each cycle spent in those states.
  - When it reaches TIMEOUT_CYCLES, all AXI valids/readies drop next cycle and the FSM goes to RSP with o_rsp_resp=2'b10, o_rsp_timeout=1, rdata=0.
  - The abort is a debug escape, not AXI-compliant recovery.
- Disabled: no counter, waits indefinitely, o_rsp_timeout tied 0.

Test Plan:
- Write addr=6, data=30, subordinate always ready → awvalid/wvalid one cycle, bready one cycle, response write=1, resp=0, rsp_valid 3 cycles after cmd accept.
- Write addr=3, data=0xAABBCCDD, awready delayed 2 cycles, wready immediate → wvalid drops first, awaddr/awvalid held until accept, single response resp=0.
- Read addr=8 returning rdata=0x1234ABCD, rresp=0 → rsp_rdata=0x1234ABCD, write=0; then i_rsp_ready low 5 cycles → response held, cmd_ready=0 throughout.
- Back-to-back: write addr=12 then read addr=12 → read returns the written value; each command accepted only after the prior response handshake.
- Reset asserted while in WR_B → next cycle all outputs 0 except cmd_ready=1 after release; no rsp_valid.
- With AXIL_MGR_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready never asserted → arvalid drops after 16 cycles in RD_AR, response resp=2'b10, timeout=1.
